uart2wb_cmd: RTL

- Command parser between the UART receiver and the Wishbone master.
- Takes received ASCII bytes and assembles them into 34-bit command words: [33:32] is the opcode, [31:0] is the payload.
- Presents each word to the Wishbone master with a valid/ready handshake.
- Malformed input and bytes arriving while a word is still pending are dropped and flagged.

---
 rtl/uart2wb_cmd.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/uart2wb_cmd.sv
// uart2wb_cmd: ASCII command parser feeding the Wishbone master.
// Assembles {opcode[1:0], payload[31:0]} words from UART bytes and
// offers each one on a valid/ready handshake.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   i_rx_data    byte from UART receiver
//   i_rx_valid   one-cycle strobe qualifying i_rx_data
//   o_WB_ctr_w   command word: [33:32] 0=rd 1=wr 2=addr 3=special
//   o_WB_cyc     command word valid
//   i_WB_ready   downstream accepts the word
//   o_err        one-cycle pulse: malformed byte, field aborted
//   o_overrun    one-cycle pulse: byte dropped while a word is pending
module uart2wb_cmd #(
    parameter int NDIGITS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    output logic [33:0] o_WB_ctr_w,
    output logic        o_WB_cyc,
    input  logic        i_WB_ready,
    output logic        o_err,
    output logic        o_overrun
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HEX  = 2'd1,
        S_EMIT = 2'd2
    } state_t;

    localparam logic [3:0] LAST_DIGIT = 4'(NDIGITS - 1);

    state_t      r_state;
    logic [1:0]  r_op;
    logic [27:0] r_shift;
    logic [3:0]  r_cnt;
    logic [33:0] r_word;
    logic        r_cyc;
    logic        r_err;
    logic        r_ovr;

    logic [7:0]  w_uc;
    logic        w_is_dec;
    logic        w_is_af;
    logic        w_is_hex;
    logic [3:0]  w_nib;
    logic        w_is_rd;
    logic        w_is_cmd;
    logic [1:0]  w_cmd_op;
    logic        w_is_ws;
    logic [31:0] w_shift_nxt;

    // Fold lower-case letters onto upper case so one decoder serves both.
    always_comb begin
        w_uc = i_rx_data;
        if (i_rx_data >= 8'h61 && i_rx_data <= 8'h7A) begin
            w_uc = i_rx_data - 8'h20;
        end
    end

    always_comb begin
        w_is_dec = (w_uc >= 8'h30) && (w_uc <= 8'h39);
        w_is_af  = (w_uc >= 8'h41) && (w_uc <= 8'h46);
        w_is_hex = w_is_dec || w_is_af;
        // '0'..'9' carry their value in the low nibble; 'A'..'F' are
        // 0x41..0x46, so low nibble + 9 gives 10..15.
        w_nib = w_uc[3:0];
        if (w_is_af) begin
            w_nib = w_uc[3:0] + 4'd9;
        end
    end

    always_comb begin
        w_is_rd  = 1'b0;
        w_is_cmd = 1'b0;
        w_cmd_op = 2'd0;
        unique case (w_uc)
            8'h52: w_is_rd = 1'b1;
            8'h57: begin
                w_is_cmd = 1'b1;
                w_cmd_op = 2'd1;
            end
            8'h41: begin
                w_is_cmd = 1'b1;
                w_cmd_op = 2'd2;
            end
            8'h53: begin
                w_is_cmd = 1'b1;
                w_cmd_op = 2'd3;
            end
            default: begin
                w_is_rd  = 1'b0;
                w_is_cmd = 1'b0;
            end
        endcase
    end

    assign w_is_ws = (i_rx_data == 8'h20) ||
                     (i_rx_data == 8'h0D) ||
                     (i_rx_data == 8'h0A);

    // Only NDIGITS nibbles are ever shifted in after a clear, so the
    // payload ends up right-aligned and zero-extended.
    assign w_shift_nxt = {r_shift, w_nib};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_op    <= 2'd0;
            r_shift <= 28'd0;
            r_cnt   <= 4'd0;
            r_word  <= 34'd0;
            r_cyc   <= 1'b0;
            r_err   <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            r_ovr <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_rx_valid) begin
                        if (w_is_rd) begin
                            r_word  <= 34'd0;
                            r_cyc   <= 1'b1;
                            r_state <= S_EMIT;
                        end else if (w_is_cmd) begin
                            r_op    <= w_cmd_op;
                            r_shift <= 28'd0;
                            r_cnt   <= 4'd0;
                            r_state <= S_HEX;
                        end else if (!w_is_ws) begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_HEX: begin
                    if (i_rx_valid) begin
                        if (w_is_hex) begin
                            if (r_cnt == LAST_DIGIT) begin
                                r_word  <= {r_op, w_shift_nxt};
                                r_cyc   <= 1'b1;
                                r_shift <= 28'd0;
                                r_cnt   <= 4'd0;
                                r_state <= S_EMIT;
                            end else begin
                                r_shift <= w_shift_nxt[27:0];
                                r_cnt   <= r_cnt + 4'd1;
                            end
                        end else begin
                            r_err   <= 1'b1;
                            r_shift <= 28'd0;
                            r_cnt   <= 4'd0;
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_EMIT: begin
                    // The completion cycle is still EMIT: a byte
                    // arriving now is dropped as well.
                    if (i_rx_valid) begin
                        r_ovr <= 1'b1;
                    end
                    if (i_WB_ready) begin
                        r_cyc   <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cyc   <= 1'b0;
                end
            endcase
        end
    end

    assign o_WB_ctr_w = r_word;
    assign o_WB_cyc   = r_cyc;
    assign o_err      = r_err;
    assign o_overrun  = r_ovr;

endmodule
